// File: rtl/video_syncgen.sv
// Raster timing generator with a selectable 24-bit test pattern.
// Every output is registered one clock after the counter position it describes.
module video_syncgen #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BACKP  = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BACKP  = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_ena,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] fill_color,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        de_out,
    output logic [23:0] pixel_out,
    output logic        frame_top
);

    localparam int HA0 = H_SYNC + H_BACKP;
    localparam int VA0 = V_SYNC + V_BACKP;
    localparam int BW  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_L = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_L = 11'(V_SYNC);
    localparam logic [10:0] HA_BEG   = 11'(HA0);
    localparam logic [10:0] HA_END   = 11'(HA0 + H_ACTIVE);
    localparam logic [10:0] VA_BEG   = 11'(VA0);
    localparam logic [10:0] VA_END   = 11'(VA0 + V_ACTIVE);
    localparam logic [10:0] BW_LAST  = 11'(BW - 1);

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic [1:0]  pattern_q, pattern_d;
    logic [10:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [23:0] pixel_q, pixel_d;
    logic        frame_top_q, frame_top_d;

    logic        h_act;
    logic        v_act;
    logic        at_origin;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic [23:0] bar_rgb;
    logic [23:0] pattern_rgb;

    assign h_act     = (hcount_q >= HA_BEG) && (hcount_q < HA_END);
    assign v_act     = (vcount_q >= VA_BEG) && (vcount_q < VA_END);
    assign at_origin = (hcount_q == 11'd0) && (vcount_q == 11'd0);
    assign pos_x     = hcount_q - HA_BEG;
    assign pos_y     = vcount_q - VA_BEG;

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pattern_rgb = 24'h000000;
        case (pattern_q)
            PAT_BARS:  pattern_rgb = bar_rgb;
            PAT_RAMP:  pattern_rgb = {pos_x[7:0], pos_x[7:0], pos_x[7:0]};
            PAT_CHECK: pattern_rgb = (pos_x[4] ^ pos_y[4]) ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: pattern_rgb = fill_color;
            default:   pattern_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        hsync_d     = 1'b1;
        vsync_d     = 1'b1;
        de_d        = 1'b0;
        pixel_d     = 24'h000000;
        frame_top_d = 1'b0;
        // The latch only samples at the raster origin so a frame never mixes patterns.
        pattern_d   = at_origin ? pattern_sel : pattern_q;

        if (!scan_ena) begin
            hcount_d  = 11'd0;
            vcount_d  = 11'd0;
            bar_cnt_d = 11'd0;
            bar_idx_d = 3'd0;
        end else begin
            hsync_d     = !(hcount_q < H_SYNC_L);
            vsync_d     = !(vcount_q < V_SYNC_L);
            de_d        = h_act && v_act;
            pixel_d     = (h_act && v_act) ? pattern_rgb : 24'h000000;
            frame_top_d = h_act && v_act && (pos_x == 11'd0) && (pos_y == 11'd0);

            if (hcount_q == H_LAST) begin
                hcount_d = 11'd0;
                vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end

            // Bar position tracks the pixel the counters will point at next; it
            // restarts in horizontal blanking and saturates on the last bar.
            if (h_act) begin
                if (bar_cnt_q == BW_LAST) begin
                    bar_cnt_d = 11'd0;
                    bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 11'd1;
                end
            end else begin
                bar_cnt_d = 11'd0;
                bar_idx_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcount_q    <= 11'd0;
            vcount_q    <= 11'd0;
            pattern_q   <= PAT_BARS;
            bar_cnt_q   <= 11'd0;
            bar_idx_q   <= 3'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            de_q        <= 1'b0;
            pixel_q     <= 24'h000000;
            frame_top_q <= 1'b0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            pattern_q   <= pattern_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            pixel_q     <= pixel_d;
            frame_top_q <= frame_top_d;
        end
    end

    assign vsync_out = vsync_q;
    assign hsync_out = hsync_q;
    assign de_out    = de_q;
    assign pixel_out = pixel_q;
    assign frame_top = frame_top_q;

endmodule

// File: tb/tb_video_syncgen.sv
// Bench for video_syncgen: a reduced raster checked every clock against a
// position-arithmetic reference model, plus directed timing and reset checks.
module tb_video_syncgen;

    localparam int HS    = 4;
    localparam int HBP   = 4;
    localparam int HA    = 266;
    localparam int HT    = 280;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int VA    = 18;
    localparam int VT    = 24;
    localparam int HA0   = HS + HBP;
    localparam int VA0   = VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW    = HA / 8;
    localparam int FIRST_DE = VA0 * HT + HA0 + 1;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scan_ena = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] fill_color = 24'h0;
    logic        vsync_out;
    logic        hsync_out;
    logic        de_out;
    logic [23:0] pixel_out;
    logic        frame_top;

    video_syncgen #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACKP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACKP(VBP), .V_ACTIVE(VA)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .scan_ena   (scan_ena),
        .pattern_sel(pattern_sel),
        .fill_color (fill_color),
        .vsync_out  (vsync_out),
        .hsync_out  (hsync_out),
        .de_out     (de_out),
        .pixel_out  (pixel_out),
        .frame_top  (frame_top)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: position index within the frame and the latched pattern.
    int          k = 0;
    logic [1:0]  pat_m = 2'd0;
    logic        exp_h, exp_v, exp_de, exp_ft;
    logic [23:0] exp_px;

    int          edge_n, first_de, ft_cnt, vs_low, hs_low;
    logic [23:0] top_px;
    bit          rand_fill = 1'b0;
    bit          rand_ctrl = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int h, v, x, y, bar;
        if (k == 0) pat_m = pattern_sel;
        exp_h  = 1'b1;
        exp_v  = 1'b1;
        exp_de = 1'b0;
        exp_px = 24'h0;
        exp_ft = 1'b0;
        if (!scan_ena) begin
            k = 0;
        end else begin
            h = k % HT;
            v = k / HT;
            exp_h  = (h >= HS);
            exp_v  = (v >= VS);
            exp_de = (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
            if (exp_de) begin
                x = h - HA0;
                y = v - VA0;
                case (pat_m)
                    2'd0: begin
                        bar = x / BW;
                        if (bar > 7) bar = 7;
                        exp_px = BARS[bar];
                    end
                    2'd1:    exp_px = 24'((x % 256) * 65793);
                    2'd2:    exp_px = (((x / 16) + (y / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                    default: exp_px = fill_color;
                endcase
                exp_ft = (x == 0) && (y == 0);
            end
            k = (k + 1) % FRAME;
        end
    endtask

    task automatic clear_stats();
        edge_n   = 0;
        first_de = 0;
        ft_cnt   = 0;
        vs_low   = 0;
        hs_low   = 0;
        top_px   = 24'h0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        edge_n++;
        check("hsync", {31'd0, hsync_out}, {31'd0, exp_h});
        check("vsync", {31'd0, vsync_out}, {31'd0, exp_v});
        check("de", {31'd0, de_out}, {31'd0, exp_de});
        check("pixel", {8'd0, pixel_out}, {8'd0, exp_px});
        check("frame_top", {31'd0, frame_top}, {31'd0, exp_ft});
        if (de_out && first_de == 0) first_de = edge_n;
        if (frame_top) begin
            ft_cnt++;
            top_px = pixel_out;
        end
        if (!vsync_out) vs_low++;
        if (!hsync_out) hs_low++;
        if (rand_fill) fill_color = 24'($urandom);
        if (rand_ctrl) begin
            pattern_sel = 2'($urandom_range(0, 3));
            scan_ena    = ($urandom_range(0, 999) != 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_idle(input string tag);
        check(tag, {28'd0, vsync_out, hsync_out, de_out, frame_top}, 32'b1100);
        check({tag, "_px"}, {8'd0, pixel_out}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset_state");

        // Frame 1: colour bars from reset release; directed timing counts.
        @(negedge clock);
        reset    = 1'b0;
        scan_ena = 1'b1;
        clear_stats();
        run(FRAME);
        check("first_de_edge", first_de, FIRST_DE);
        check("frame_top_count", ft_cnt, 1);
        check("vsync_low_clocks", vs_low, VS * HT);
        check("hsync_low_clocks", hs_low, HS * VT);
        check("bars_top_pixel", {8'd0, top_px}, 32'hFFFFFF);
        $display("frame bars: first_de=%0d frame_top=%0d vs_low=%0d hs_low=%0d", first_de, ft_cnt, vs_low, hs_low);

        pattern_sel = 2'd1;
        clear_stats();
        run(FRAME);
        check("ramp_frame_top_count", ft_cnt, 1);
        $display("frame ramp: frame_top=%0d errors=%0d", ft_cnt, errors);

        pattern_sel = 2'd2;
        clear_stats();
        run(FRAME);
        $display("frame checker: frame_top=%0d errors=%0d", ft_cnt, errors);

        // Mid-frame switch to solid: current frame must stay bars.
        pattern_sel = 2'd0;
        run(FRAME / 2);
        pattern_sel = 2'd3;
        fill_color  = 24'h123456;
        run(FRAME - FRAME / 2);
        clear_stats();
        run(FRAME);
        check("solid_top_pixel", {8'd0, top_px}, 32'h123456);
        check("solid_frame_top_count", ft_cnt, 1);
        $display("frame solid: top_px=%06h errors=%0d", top_px, errors);

        // Drop scan_ena mid-frame, hold 10 clocks, restart.
        rand_fill   = 1'b1;
        pattern_sel = 2'd0;
        run(15 * HT + 100);
        scan_ena = 1'b0;
        run(1);
        check_idle("drop_idle");
        run(9);
        scan_ena = 1'b1;
        clear_stats();
        run(1);
        check("restart_vsync", {31'd0, vsync_out}, 32'd0);
        check("restart_hsync", {31'd0, hsync_out}, 32'd0);
        run(FRAME - 1);
        check("restart_first_de", first_de, FIRST_DE);
        check("restart_frame_top_count", ft_cnt, 1);
        $display("restart: first_de=%0d frame_top=%0d", first_de, ft_cnt);

        // Random controls: pattern changes every clock, occasional scan drops.
        rand_ctrl = 1'b1;
        run(2 * FRAME);
        rand_ctrl = 1'b0;
        scan_ena  = 1'b1;
        $display("random phase: checks=%0d errors=%0d", checks, errors);

        // Asynchronous reset in the middle of a line.
        run(3 * HT + 50);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        k     = 0;
        pat_m = 2'd0;
        repeat (2) @(posedge clock);
        #1;
        check_idle("reset_held");
        @(negedge clock);
        reset       = 1'b0;
        pattern_sel = 2'd3;
        clear_stats();
        run(FRAME);
        check("post_reset_first_de", first_de, FIRST_DE);
        check("post_reset_frame_top_count", ft_cnt, 1);
        $display("post reset: first_de=%0d frame_top=%0d", first_de, ft_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_syncgen.md
# video_syncgen

Video timing and test-pattern source that sits directly upstream of the logo overlay stage. It generates the raster (active-low hsync/vsync, active-high de) and a selectable 24-bit test pattern. All outputs come from registers, and the output bundle connects straight to the overlay's vsync_in/hsync_in/de_in/pixel_in.

## Interface
- H_TOTAL, 800, total clocks per line
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACKP, 48, horizontal back porch (clocks)
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, total lines per frame
- V_SYNC, 2, vsync pulse width (lines)
- V_BACKP, 33, vertical back porch (lines)
- V_ACTIVE, 480, visible lines per frame
- reset: reset, asynchronous, active-high. clock: clock.
- clock  in  1  pixel clock, rising-edge
- reset  in  1  asynchronous, active-high
- scan_ena  in  1  1 = raster runs; 0 = counters held at origin and outputs idle
- pattern_sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
- fill_color  in  24  RGB888 colour used for pattern 3
- vsync_out  out  1  active-low vertical sync
- hsync_out  out  1  active-low horizontal sync
- de_out  out  1  active-high data enable
- pixel_out  out  24  {R[7:0],G[7:0],B[7:0]}, 0 outside de
- frame_top  out  1  one-clock pulse with the first visible pixel of the frame

## Operation
- Counters: hcount 0..H_TOTAL-1 and vcount 0..V_TOTAL-1, each 11 bits.
  - hcount wraps to 0 after H_TOTAL-1.
  - vcount increments on the hcount wrap and wraps to 0 after V_TOTAL-1.
- Regions, with HA0 = H_SYNC+H_BACKP and VA0 = V_SYNC+V_BACKP:
  - hsync active when hcount < H_SYNC.
  - vsync active when vcount < V_SYNC.
  - de when HA0 <= hcount < HA0+H_ACTIVE and VA0 <= vcount < VA0+V_ACTIVE.
- Position: x = hcount-HA0 and y = vcount-VA0, both 11-bit unsigned. They are valid only in de.
- Patterns:
  - 0: eight bars, in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Bar width BW = H_ACTIVE/8 (integer division). The bar index is kept by a per-line bar counter, not a divider. The index saturates at 7, so any remainder pixels are black.
  - 1: R=G=B=x[7:0]. The ramp wraps every 256 pixels.
  - 2: FFFFFF when x[4]^y[4] is 1, else 000000 (16x16 cells).
  - 3: fill_color, sampled every pixel.
- pattern_sel is latched into an internal register only when hcount==0 and vcount==0. A pattern change therefore never tears mid-frame. Reset value of the latch is 0.
- scan_ena=0 (also when deasserted mid-frame): on the next edge, counters go to 0 and all outputs go to their reset values. Re-assertion restarts a full frame from hcount=vcount=0.
- Reset values: hsync_out=1, vsync_out=1, de_out=0, pixel_out=000000, frame_top=0, hcount=vcount=0.

## Timing
- On each edge with scan_ena=1, the outputs register the decode of the current counters, and the counters then advance. The counter-to-output latency is therefore 1 clock.
- All five outputs are mutually aligned; no output has extra skew.
- First edge after reset with scan_ena=1: hsync_out=0 and vsync_out=0.
- hsync_out low for exactly H_SYNC clocks per line; vsync_out low for exactly V_SYNC*H_TOTAL clocks per frame.
- vsync and hsync fall on the same edge at the frame start.
- de_out high for H_ACTIVE consecutive clocks on each of V_ACTIVE lines.
- frame_top is coincident with the first de_out of the frame (x=0, y=0), once per frame.
- Frame period is H_TOTAL*V_TOTAL clocks (default 420000).

## Test plan
- Reset released, scan_ena=1, defaults:
  - hsync low 96 of every 800 clocks.
  - vsync low for 1600 clocks.
  - First de at edge 35*800+144+1 = 28145 after reset release.
  - frame_top pulses exactly once per 420000 clocks.
- pattern_sel=0: on the first visible line, pixel_out is FFFFFF for x=0..79, FFFF00 at x=80, and 000000 at x=560..639. pixel_out=0 whenever de=0.
- pattern_sel=1: x=255 gives FFFFFF and x=256 gives 000000. pattern_sel=2: (x,y)=(16,0) gives FFFFFF and (16,16) gives 000000.
- Change pattern_sel 0->3 at mid-frame:
  - The current frame stays bars.
  - The next frame is fill_color.
  - fill_color=123456 gives pixel_out=123456.
- Drop scan_ena at vcount=200; hold it low 10 clocks, then raise it.
  - Next edge: outputs are 1/1/0/0.
  - After re-assertion, a clean frame starts with vsync low on the first edge.
  - First de follows 28144 clocks later.
- Assert reset mid-line: outputs go to reset values immediately (asynchronously). pattern latch = 0 after release.
